fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Front end that feeds the control unit: holds the PC, fetches each instruction through the icache handshake, and registers it as instr.
- Sequences the optional data-memory access through the dcache handshake.
- Computes next-PC from the control unit's PCSrc/zero_sel decode, and emits a one-cycle commit strobe that qualifies register-file writes.
- Stops permanently once the halt flag is raised.

Parameters:
- PC_INIT, 32'h00000000, PC value loaded at reset.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  icache hit; imemload is valid this cycle.
- imemload  in  32  instruction word from the icache.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  instruction address (= pc).
- instr  out  32  registered instruction, to the control unit.
- pc_plus4  out  32  pc+4, used for JAL writeback to R31.
- pc_src  in  2  pcsrc_t: ADD4_DIAOSI, JUMP_DIAOSI, JR_DIAOSI, BRANCH_DIAOSI.
- zero_sel  in  1  zerosel_t: BEQ_DIAOSI or BNE_DIAOSI.
- zero_f  in  1  ALU zero flag.
- j_addr26  in  26  jump target field.
- imm16  in  16  branch offset field.
- rdat1  in  32  register rs value, the JR target.
- d_ren  in  1  current instruction is a load.
- d_wen  in  1  current instruction is a store.
- halt  in  1  registered halt flag from the control unit.
- dhit  in  1  dcache hit.
- dmemREN  out  1  data read request.
- dmemWEN  out  1  data write request.
- commit  out  1  one-cycle pulse: instruction retires; gates register-file write enable.

Behaviour:
- Reset (asynchronous, any state, mid-access included):
  - state=FETCH, pc=PC_INIT, instr=0.
  - Outputs: imemREN=0 during reset; dmemREN=0, dmemWEN=0, commit=0.
- States: FETCH, EXEC, MEM, HALTED. All outputs are Moore-decoded from state, except commit.
- FETCH:
  - imemREN=1, imemaddr=pc.
  - On ihit: instr<=imemload; go to EXEC.
  - Without ihit: hold; pc and instr unchanged.
- EXEC (decode is valid; control unit is combinational on instr):
  - halt=1 → HALTED; no commit; pc unchanged.
  - Else if d_ren or d_wen → MEM.
  - Else commit=1, pc<=npc, go to FETCH.
- MEM:
  - dmemREN=d_ren, dmemWEN=d_wen, held stable until dhit.
  - On dhit: commit=1, pc<=npc, go to FETCH. The load data is consumed in this same cycle.
- HALTED:
  - Terminal until reset.
  - imemREN=dmemREN=dmemWEN=commit=0.
- Spurious hits are ignored: ihit outside FETCH and dhit outside MEM. If ihit and dhit are simultaneous, only the one matching the current state acts.
- npc (combinational, 32-bit, wrap-around modulo 2^32, no overflow trap):
  - ADD4: pc+4.
  - JUMP: {pc_plus4[31:28], j_addr26, 2'b00}.
  - JR: rdat1, unaligned values passed through unchanged.
  - BRANCH: taken = (zero_sel==BEQ_DIAOSI) ? zero_f : !zero_f. Target = pc+4 + (sign-extended imm16 << 2) if taken, else pc+4.
- Latency: non-memory instruction = 2 cycles minimum (FETCH with ihit, then EXEC). Memory instruction = 3 cycles minimum, plus cache wait cycles.
- commit is asserted at most once per fetched instruction; pc changes only on the commit cycle.

Decomposition:
- diaosi_types_pkg holds:
  - pcsrc_t and zerosel_t (already used by the control unit).
  - New fsm_state_t {FETCH, EXEC, MEM, HALTED}.
  - Constant WORD_INC=32'd4.
- One sub-module, next_pc_calc: combinational npc mux and branch adder. It is tested standalone.

Test Plan:
- Reset then ADD4: ihit every FETCH with imemload=32'h20010005, pc_src=ADD4 → imemaddr 0,4,8; commit one pulse per 2 cycles; instr=32'h20010005 after first ihit.
- ihit held low 3 cycles in FETCH → imemREN stays 1, pc stays 0, no commit; 4th cycle ihit → EXEC next cycle.
- LW with dhit delayed 2 cycles: d_ren=1 → MEM with dmemREN=1 for 3 cycles, commit only on dhit cycle, then pc=4.
- Branch at pc=32'h10 with BEQ, zero_f=1, imm16=16'hFFFC → pc=32'h04; same with zero_f=0 → 32'h14; BNE with zero_f=0, imm16=2 → 32'h1C.
- JUMP at pc=32'h40000000, j_addr26=26'h10 → pc=32'h40000040. JR with rdat1=32'h0000ABC0 → pc=32'h0000ABC0.
- halt=1 in EXEC → HALTED; later ihit/dhit pulses give no requests or commit; nRST low mid-MEM → dmemREN drops immediately, pc=PC_INIT.

Source files
------------

// File: rtl/diaosi_types_pkg.sv
// ---------------------------------------------------------------------------
// diaosi_types_pkg
// Shared types for the diaosi core front end.
//   pcsrc_t     : next-PC source selected by the control unit decode
//   zerosel_t   : branch sense (BEQ takes on zero, BNE on non-zero)
//   fsm_state_t : fetch sequencer states
//   WORD_INC    : byte distance between consecutive instruction words
// ---------------------------------------------------------------------------
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        ADD4_DIAOSI   = 2'd0,
        JUMP_DIAOSI   = 2'd1,
        JR_DIAOSI     = 2'd2,
        BRANCH_DIAOSI = 2'd3
    } pcsrc_t;

    typedef enum logic {
        BEQ_DIAOSI = 1'b0,
        BNE_DIAOSI = 1'b1
    } zerosel_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } fsm_state_t;

    localparam logic [31:0] WORD_INC = 32'd4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the icache/dcache handshakes and the control-unit decode signals
// seen by the fetch sequencer.
//   master : the fetch sequencer side (drives requests, instr, pc_plus4, commit)
//   slave  : the caches + control unit side (drives hits, load data, decode)
// ---------------------------------------------------------------------------
interface fetch_sequencer_if;
    import diaosi_types_pkg::*;

    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    pcsrc_t      pc_src;
    zerosel_t    zero_sel;
    logic        zero_f;
    logic [25:0] j_addr26;
    logic [15:0] imm16;
    logic [31:0] rdat1;
    logic        d_ren;
    logic        d_wen;
    logic        halt;
    logic        dhit;
    logic        dmemREN;
    logic        dmemWEN;
    logic        commit;

    modport master (
        input  ihit, imemload, pc_src, zero_sel, zero_f, j_addr26, imm16,
               rdat1, d_ren, d_wen, halt, dhit,
        output imemREN, imemaddr, instr, pc_plus4, dmemREN, dmemWEN, commit
    );

    modport slave (
        output ihit, imemload, pc_src, zero_sel, zero_f, j_addr26, imm16,
               rdat1, d_ren, d_wen, halt, dhit,
        input  imemREN, imemaddr, instr, pc_plus4, dmemREN, dmemWEN, commit
    );

endinterface

// File: rtl/next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Combinational next-PC selection and branch target adder. All arithmetic
// wraps modulo 2^32.
//   i_pc        current PC
//   i_pcSrc     next-PC source from decode
//   i_zeroSel   branch sense (BEQ/BNE)
//   i_zeroF     ALU zero flag
//   i_jAddr26   jump target field
//   i_imm16     branch word offset
//   i_rdat1     register target for JR (passed through as-is)
//   o_npc       selected next PC
//   o_pcPlus4   i_pc + 4
// ---------------------------------------------------------------------------
module next_pc_calc
    import diaosi_types_pkg::*;
(
    input  logic [31:0] i_pc,
    input  pcsrc_t      i_pcSrc,
    input  zerosel_t    i_zeroSel,
    input  logic        i_zeroF,
    input  logic [25:0] i_jAddr26,
    input  logic [15:0] i_imm16,
    input  logic [31:0] i_rdat1,
    output logic [31:0] o_npc,
    output logic [31:0] o_pcPlus4
);

    logic [31:0] w_pcPlus4;
    logic [31:0] w_branchOffset;
    logic        w_taken;

    assign w_pcPlus4      = i_pc + WORD_INC;
    // Word offset becomes a byte offset: sign-extend then shift left by two.
    assign w_branchOffset = {{14{i_imm16[15]}}, i_imm16, 2'b00};
    assign w_taken        = (i_zeroSel == BEQ_DIAOSI) ? i_zeroF : !i_zeroF;
    assign o_pcPlus4      = w_pcPlus4;

    // Pick the next PC; the jump target keeps the region bits of pc+4.
    always_comb begin
        o_npc = w_pcPlus4;
        case (i_pcSrc)
            ADD4_DIAOSI:   o_npc = w_pcPlus4;
            JUMP_DIAOSI:   o_npc = {w_pcPlus4[31:28], i_jAddr26, 2'b00};
            JR_DIAOSI:     o_npc = i_rdat1;
            BRANCH_DIAOSI: o_npc = w_taken ? (w_pcPlus4 + w_branchOffset) : w_pcPlus4;
            default:       o_npc = w_pcPlus4;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Core front end: holds the PC, fetches through the icache handshake,
// registers the instruction for the control unit, sequences the optional
// dcache access, and pulses commit once per retired instruction. Stops for
// good once halt is seen in EXEC.
//   CLK   system clock, rising edge
//   nRST  asynchronous active-low reset
//   bus   fetch_sequencer_if.master (caches + control unit signals)
// ---------------------------------------------------------------------------
module fetch_sequencer
    import diaosi_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic               CLK,
    input  logic               nRST,
    fetch_sequencer_if.master  bus
);

    fsm_state_t  r_state;
    fsm_state_t  w_nextState;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] w_npc;
    logic [31:0] w_pcPlus4;
    logic        w_loadInstr;
    logic        w_commit;
    logic        w_fetchReq;
    logic        w_dRen;
    logic        w_dWen;

    next_pc_calc u_nextPc (
        .i_pc      (r_pc),
        .i_pcSrc   (bus.pc_src),
        .i_zeroSel (bus.zero_sel),
        .i_zeroF   (bus.zero_f),
        .i_jAddr26 (bus.j_addr26),
        .i_imm16   (bus.imm16),
        .i_rdat1   (bus.rdat1),
        .o_npc     (w_npc),
        .o_pcPlus4 (w_pcPlus4)
    );

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and request decode. Hits that do not match the current
    // state are simply not looked at, so spurious hits are ignored.
    always_comb begin
        w_nextState = r_state;
        w_loadInstr = 1'b0;
        w_commit    = 1'b0;
        w_fetchReq  = 1'b0;
        w_dRen      = 1'b0;
        w_dWen      = 1'b0;
        case (r_state)
            FETCH: begin
                w_fetchReq = 1'b1;
                if (bus.ihit) begin
                    w_loadInstr = 1'b1;
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                if (bus.halt) begin
                    w_nextState = HALTED;
                end else if (bus.d_ren || bus.d_wen) begin
                    w_nextState = MEM;
                end else begin
                    w_commit    = 1'b1;
                    w_nextState = FETCH;
                end
            end
            MEM: begin
                w_dRen = bus.d_ren;
                w_dWen = bus.d_wen;
                if (bus.dhit) begin
                    w_commit    = 1'b1;
                    w_nextState = FETCH;
                end
            end
            HALTED: begin
                w_nextState = HALTED;
            end
            default: begin
                w_nextState = FETCH;
            end
        endcase
    end

    // PC and instruction registers; the PC only moves on a commit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pc    <= PC_INIT;
            r_instr <= 32'h0;
        end else begin
            if (w_loadInstr) begin
                r_instr <= bus.imemload;
            end
            if (w_commit) begin
                r_pc <= w_npc;
            end
        end
    end

    // The state resets to FETCH, so the fetch request is masked while
    // reset is held to keep the icache quiet.
    assign bus.imemREN  = w_fetchReq & nRST;
    assign bus.imemaddr = r_pc;
    assign bus.instr    = r_instr;
    assign bus.pc_plus4 = w_pcPlus4;
    assign bus.dmemREN  = w_dRen;
    assign bus.dmemWEN  = w_dWen;
    assign bus.commit   = w_commit;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer: a table of next-PC vectors run as
// full fetch/exec instructions, plus hand-written multi-cycle sequences for
// fetch stalls, memory waits, halt and reset mid-access.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;
    import diaosi_types_pkg::*;

    typedef struct {
        logic [31:0] startPc;
        pcsrc_t      pcSrc;
        zerosel_t    zeroSel;
        logic        zeroF;
        logic [25:0] j26;
        logic [15:0] imm;
        logic [31:0] rdat1;
        logic [31:0] expPc;
    } vec_t;

    localparam int NUM_VECS = 11;

    logic CLK;
    logic nRST;
    int   total;
    int   bad;
    vec_t vecs [NUM_VECS];

    fetch_sequencer_if bus ();

    fetch_sequencer #(.PC_INIT(32'h00000000)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Decode inputs the control unit would present for the current instr.
    task automatic applyStimulus(input pcsrc_t src, input zerosel_t zs, input logic zf,
                                 input logic [25:0] j26, input logic [15:0] imm,
                                 input logic [31:0] rd1, input logic ren, input logic wen,
                                 input logic hlt);
        bus.pc_src   = src;
        bus.zero_sel = zs;
        bus.zero_f   = zf;
        bus.j_addr26 = j26;
        bus.imm16    = imm;
        bus.rdat1    = rd1;
        bus.d_ren    = ren;
        bus.d_wen    = wen;
        bus.halt     = hlt;
    endtask

    // One-cycle icache hit while in FETCH; returns with the DUT in EXEC.
    task automatic fetchOne(input logic [31:0] word);
        bus.ihit     = 1'b1;
        bus.imemload = word;
        tick();
        bus.ihit     = 1'b0;
    endtask

    task automatic doReset();
        nRST = 1'b0;
        bus.ihit = 1'b0;
        bus.dhit = 1'b0;
        bus.imemload = 32'h0;
        applyStimulus(ADD4_DIAOSI, BEQ_DIAOSI, 1'b0, 26'h0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        nRST = 1'b1;
        #1;
    endtask

    // Steer the PC anywhere with a JR instruction; ends in FETCH.
    task automatic setPc(input logic [31:0] target);
        applyStimulus(JR_DIAOSI, BEQ_DIAOSI, 1'b0, 26'h0, 16'h0, target, 1'b0, 1'b0, 1'b0);
        fetchOne(32'h03E00008);
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = '{32'h00000010, BRANCH_DIAOSI, BEQ_DIAOSI, 1'b1, 26'h0,       16'hFFFC, 32'h0,        32'h00000004};
        vecs[1]  = '{32'h00000010, BRANCH_DIAOSI, BEQ_DIAOSI, 1'b0, 26'h0,       16'hFFFC, 32'h0,        32'h00000014};
        vecs[2]  = '{32'h00000010, BRANCH_DIAOSI, BNE_DIAOSI, 1'b0, 26'h0,       16'h0002, 32'h0,        32'h0000001C};
        vecs[3]  = '{32'h00000010, BRANCH_DIAOSI, BNE_DIAOSI, 1'b1, 26'h0,       16'h0002, 32'h0,        32'h00000014};
        vecs[4]  = '{32'h40000000, JUMP_DIAOSI,   BEQ_DIAOSI, 1'b0, 26'h10,      16'h0,    32'h0,        32'h40000040};
        vecs[5]  = '{32'h00000020, JR_DIAOSI,     BEQ_DIAOSI, 1'b0, 26'h0,       16'h0,    32'h0000ABC0, 32'h0000ABC0};
        vecs[6]  = '{32'h00000000, JR_DIAOSI,     BNE_DIAOSI, 1'b1, 26'h0,       16'h0,    32'h00000123, 32'h00000123};
        vecs[7]  = '{32'hFFFFFFFC, ADD4_DIAOSI,   BEQ_DIAOSI, 1'b0, 26'h0,       16'h0,    32'h0,        32'h00000000};
        vecs[8]  = '{32'hFFFFFFFC, BRANCH_DIAOSI, BEQ_DIAOSI, 1'b1, 26'h0,       16'h0001, 32'h0,        32'h00000004};
        vecs[9]  = '{32'hF0000000, JUMP_DIAOSI,   BEQ_DIAOSI, 1'b0, 26'h3FFFFFF, 16'h0,    32'h0,        32'hFFFFFFFC};
        vecs[10] = '{32'h00100000, BRANCH_DIAOSI, BEQ_DIAOSI, 1'b1, 26'h0,       16'h8000, 32'h0,        32'h000E0004};

        // Reset state while nRST is held low.
        nRST = 1'b0;
        bus.ihit = 1'b0;
        bus.dhit = 1'b0;
        bus.imemload = 32'h0;
        applyStimulus(ADD4_DIAOSI, BEQ_DIAOSI, 1'b0, 26'h0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #3;
        checkOutput("rst_imemREN", 32'(bus.imemREN), 32'h0);
        checkOutput("rst_dmemREN", 32'(bus.dmemREN), 32'h0);
        checkOutput("rst_dmemWEN", 32'(bus.dmemWEN), 32'h0);
        checkOutput("rst_commit",  32'(bus.commit),  32'h0);
        checkOutput("rst_pc",      bus.imemaddr,     32'h0);
        checkOutput("rst_instr",   bus.instr,        32'h0);
        tick();
        tick();
        nRST = 1'b1;
        #1;
        checkOutput("post_rst_imemREN", 32'(bus.imemREN), 32'h1);

        // ADD4 stream with ihit held high: one commit every two cycles.
        bus.imemload = 32'h20010005;
        bus.ihit = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("add4_addr%0d", k), bus.imemaddr, 32'(4 * k));
            checkOutput($sformatf("add4_fetch_commit%0d", k), 32'(bus.commit), 32'h0);
            checkOutput($sformatf("add4_ren%0d", k), 32'(bus.imemREN), 32'h1);
            tick();
            checkOutput($sformatf("add4_exec_commit%0d", k), 32'(bus.commit), 32'h1);
            checkOutput($sformatf("add4_instr%0d", k), bus.instr, 32'h20010005);
            checkOutput($sformatf("add4_exec_ren%0d", k), 32'(bus.imemREN), 32'h0);
            tick();
        end
        bus.ihit = 1'b0;
        checkOutput("add4_final_pc", bus.imemaddr, 32'hC);

        // Icache miss for three cycles: request held, nothing moves.
        doReset();
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("stall_ren%0d", k), 32'(bus.imemREN), 32'h1);
            checkOutput($sformatf("stall_pc%0d", k), bus.imemaddr, 32'h0);
            checkOutput($sformatf("stall_commit%0d", k), 32'(bus.commit), 32'h0);
            checkOutput($sformatf("stall_instr%0d", k), bus.instr, 32'h0);
        end
        fetchOne(32'h00221820);
        checkOutput("stall_exec_commit", 32'(bus.commit), 32'h1);
        checkOutput("stall_exec_instr", bus.instr, 32'h00221820);
        tick();
        checkOutput("stall_next_pc", bus.imemaddr, 32'h4);

        // Load with the dcache hit arriving on the third MEM cycle.
        doReset();
        applyStimulus(ADD4_DIAOSI, BEQ_DIAOSI, 1'b0, 26'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        bus.dhit = 1'b1;
        fetchOne(32'h8C220000);
        bus.dhit = 1'b0;
        checkOutput("lw_exec_commit", 32'(bus.commit), 32'h0);
        checkOutput("lw_exec_dren", 32'(bus.dmemREN), 32'h0);
        tick();
        checkOutput("lw_mem1_dren", 32'(bus.dmemREN), 32'h1);
        checkOutput("lw_mem1_dwen", 32'(bus.dmemWEN), 32'h0);
        checkOutput("lw_mem1_commit", 32'(bus.commit), 32'h0);
        bus.ihit = 1'b1;
        tick();
        bus.ihit = 1'b0;
        checkOutput("lw_mem2_dren", 32'(bus.dmemREN), 32'h1);
        checkOutput("lw_mem2_commit", 32'(bus.commit), 32'h0);
        checkOutput("lw_mem2_pc", bus.imemaddr, 32'h0);
        tick();
        bus.dhit = 1'b1;
        #1;
        checkOutput("lw_mem3_dren", 32'(bus.dmemREN), 32'h1);
        checkOutput("lw_mem3_commit", 32'(bus.commit), 32'h1);
        tick();
        bus.dhit = 1'b0;
        bus.d_ren = 1'b0;
        checkOutput("lw_done_pc", bus.imemaddr, 32'h4);
        checkOutput("lw_done_dren", 32'(bus.dmemREN), 32'h0);
        checkOutput("lw_done_commit", 32'(bus.commit), 32'h0);

        // Store with an immediate dcache hit.
        applyStimulus(ADD4_DIAOSI, BEQ_DIAOSI, 1'b0, 26'h0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        fetchOne(32'hAC220000);
        checkOutput("sw_exec_commit", 32'(bus.commit), 32'h0);
        bus.dhit = 1'b1;
        tick();
        checkOutput("sw_mem_dwen", 32'(bus.dmemWEN), 32'h1);
        checkOutput("sw_mem_dren", 32'(bus.dmemREN), 32'h0);
        checkOutput("sw_mem_commit", 32'(bus.commit), 32'h1);
        tick();
        bus.dhit = 1'b0;
        bus.d_wen = 1'b0;
        checkOutput("sw_done_pc", bus.imemaddr, 32'h8);

        // Next-PC table: each vector is one complete non-memory instruction.
        for (int i = 0; i < NUM_VECS; i++) begin
            setPc(vecs[i].startPc);
            checkOutput($sformatf("vec%0d_start", i), bus.imemaddr, vecs[i].startPc);
            applyStimulus(vecs[i].pcSrc, vecs[i].zeroSel, vecs[i].zeroF, vecs[i].j26,
                          vecs[i].imm, vecs[i].rdat1, 1'b0, 1'b0, 1'b0);
            fetchOne(32'h0);
            checkOutput($sformatf("vec%0d_commit", i), 32'(bus.commit), 32'h1);
            checkOutput($sformatf("vec%0d_pcplus4", i), bus.pc_plus4, vecs[i].startPc + 32'd4);
            tick();
            checkOutput($sformatf("vec%0d_npc", i), bus.imemaddr, vecs[i].expPc);
        end

        // Halt: terminal, all hits ignored afterwards.
        setPc(32'h00000200);
        applyStimulus(ADD4_DIAOSI, BEQ_DIAOSI, 1'b0, 26'h0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        fetchOne(32'hFFFFFFFF);
        checkOutput("halt_exec_commit", 32'(bus.commit), 32'h0);
        tick();
        applyStimulus(ADD4_DIAOSI, BEQ_DIAOSI, 1'b0, 26'h0, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        bus.ihit = 1'b1;
        bus.dhit = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("halted_iren%0d", k), 32'(bus.imemREN), 32'h0);
            checkOutput($sformatf("halted_dren%0d", k), 32'(bus.dmemREN), 32'h0);
            checkOutput($sformatf("halted_dwen%0d", k), 32'(bus.dmemWEN), 32'h0);
            checkOutput($sformatf("halted_commit%0d", k), 32'(bus.commit), 32'h0);
            checkOutput($sformatf("halted_pc%0d", k), bus.imemaddr, 32'h200);
            tick();
        end

        // Reset in the middle of a load: requests drop immediately.
        doReset();
        setPc(32'h00000300);
        applyStimulus(ADD4_DIAOSI, BEQ_DIAOSI, 1'b0, 26'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        fetchOne(32'h8C220004);
        tick();
        checkOutput("midmem_dren", 32'(bus.dmemREN), 32'h1);
        checkOutput("midmem_pc", bus.imemaddr, 32'h300);
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("midrst_dren", 32'(bus.dmemREN), 32'h0);
        checkOutput("midrst_iren", 32'(bus.imemREN), 32'h0);
        checkOutput("midrst_pc", bus.imemaddr, 32'h0);
        checkOutput("midrst_instr", bus.instr, 32'h0);
        checkOutput("midrst_commit", 32'(bus.commit), 32'h0);
        bus.d_ren = 1'b0;
        tick();
        nRST = 1'b1;
        #1;
        checkOutput("midrst_release_iren", 32'(bus.imemREN), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
